// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: default widths, reset PC and
// the fetch state encoding.
package cpu_pkg;
  localparam int CPU_ADDR_W   = 15;
  localparam int CPU_DATA_W   = 16;
  localparam int CPU_RESET_PC = 0;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    ISSUE  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/and_gate.sv
// Elementary two-input AND gate.
module and_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

// File: rtl/pc_incrementer.sv
// Combinational W-bit +1: a chain of half adders, carry-in tied high.
// The top carry is dropped so all-ones wraps to zero.
module pc_incrementer #(
  parameter int W = 15
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);
  logic [W-1:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_ha
    xor_gate u_sum (.a(a[i]), .b(carry[i]), .y(y[i]));
    if (i < W-1) begin : g_carry
      and_gate u_cy (.a(a[i]), .b(carry[i]), .y(carry[i+1]));
    end
  end
endmodule

// File: rtl/xor_gate.sv
// Elementary two-input XOR gate.
module xor_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/ack memory read, instruction register
// with valid/ready output, jump redirect and halt/resume.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = CPU_ADDR_W,
  parameter int DATA_W   = CPU_DATA_W,
  parameter int RESET_PC = CPU_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              halt,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);
  fetch_state_t      state;
  logic              pend;
  logic [ADDR_W-1:0] pend_tgt;
  logic [ADDR_W-1:0] pc_inc;

  pc_incrementer #(.W(ADDR_W)) u_inc (.a(pc), .y(pc_inc));

  assign mem_req  = (state == FETCH);
  assign mem_addr = pc;
  assign halted   = (state == HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= ADDR_W'(RESET_PC);
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      pend        <= 1'b0;
      pend_tgt    <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ack) begin
            // A redirect seen during the request voids the returned word.
            if (jump || pend) begin
              pc   <= jump ? jump_target : pend_tgt;
              pend <= 1'b0;
            end else begin
              instr       <= mem_rdata;
              instr_pc    <= pc;
              pc          <= pc_inc;
              instr_valid <= 1'b1;
              state       <= ISSUE;
            end
          end else if (jump) begin
            pend     <= 1'b1;
            pend_tgt <= jump_target;
          end
        end
        ISSUE: begin
          if (jump) begin
            instr_valid <= 1'b0;
            pc          <= jump_target;
            state       <= FETCH;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= halt ? HALTED : FETCH;
          end
        end
        HALTED: begin
          if (jump) begin
            pc    <= jump_target;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked
// against a transaction-level model of the fetch/issue stream.
module tb_fetch_unit;
  localparam int AW = 15;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready = 1'b0;
  logic          jump = 1'b0;
  logic [AW-1:0] jump_target = '0;
  logic          halt = 1'b0;
  logic          halted;
  logic [AW-1:0] pc;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .jump(jump), .jump_target(jump_target), .halt(halt), .halted(halted), .pc(pc)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return {a[6:0], a[14:6]} ^ 16'hA5C3;
  endfunction

  task automatic clear_inputs();
    mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
    jump = 1'b0; jump_target = '0; halt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", instr_valid); end
    checks++; if (instr !== 16'h0) begin errors++; $display("FAIL reset_instr got %h want 0000", instr); end
    checks++; if (instr_pc !== 15'h0) begin errors++; $display("FAIL reset_instr_pc got %h want 0000", instr_pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b want 0", halted); end
    checks++; if (pc !== 15'h0) begin errors++; $display("FAIL reset_pc got %h want 0000", pc); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 15'h0) begin
      errors++; $display("FAIL reset_first_req got req=%0b addr=%h want req=1 addr=0000", mem_req, mem_addr);
    end
  endtask

  task automatic test_sequential();
    logic [DW-1:0] data [3];
    data[0] = 16'h1111; data[1] = 16'h2222; data[2] = 16'h3333;
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (mem_req !== 1'b1 || mem_addr !== AW'(k)) begin
        errors++; $display("FAIL seq_req[%0d] got req=%0b addr=%h want req=1 addr=%h", k, mem_req, mem_addr, AW'(k));
      end
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = data[k];
      @(negedge clk);
      mem_ack = 1'b0;
      checks++; if (instr_valid !== 1'b1 || instr !== data[k] || instr_pc !== AW'(k)) begin
        errors++; $display("FAIL seq_issue[%0d] got v=%0b instr=%h pc=%h want v=1 instr=%h pc=%h",
                           k, instr_valid, instr, instr_pc, data[k], AW'(k));
      end
      @(negedge clk);
    end
    checks++; if (pc !== 15'd3) begin errors++; $display("FAIL seq_pc got %h want 0003", pc); end
  endtask

  task automatic test_backpressure();
    instr_ready = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'h4444;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (instr_valid !== 1'b1 || instr !== 16'h4444 || instr_pc !== 15'd3 || mem_req !== 1'b0 || pc !== 15'd4) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%0b instr=%h ipc=%h req=%0b pc=%h want v=1 instr=4444 ipc=0003 req=0 pc=0004",
                           i, instr_valid, instr, instr_pc, mem_req, pc);
      end
      @(negedge clk);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 15'd4 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got req=%0b addr=%h v=%0b want req=1 addr=0004 v=0", mem_req, mem_addr, instr_valid);
    end
  endtask

  task automatic test_jump_pending();
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (mem_addr !== 15'd5 || mem_req !== 1'b1) begin
      errors++; $display("FAIL jp_at5 got req=%0b addr=%h want req=1 addr=0005", mem_req, mem_addr);
    end
    jump = 1'b1; jump_target = 15'h40;
    @(negedge clk);
    jump = 1'b0; jump_target = '0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 15'd5) begin
        errors++; $display("FAIL jp_wait[%0d] got v=%0b req=%0b addr=%h want v=0 req=1 addr=0005", i, instr_valid, mem_req, mem_addr);
      end
      @(negedge clk);
    end
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 15'h40) begin
      errors++; $display("FAIL jp_discard got v=%0b req=%0b addr=%h want v=0 req=1 addr=0040", instr_valid, mem_req, mem_addr);
    end
    mem_rdata = 16'h4040;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr !== 16'h4040 || instr_pc !== 15'h40) begin
      errors++; $display("FAIL jp_issue got v=%0b instr=%h ipc=%h want v=1 instr=4040 ipc=0040", instr_valid, instr, instr_pc);
    end
    @(negedge clk);
  endtask

  task automatic test_halt_resume();
    jump = 1'b1; jump_target = 15'd7; mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    @(negedge clk);
    jump = 1'b0; mem_ack = 1'b0;
    checks++; if (mem_addr !== 15'd7 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL halt_goto7 got addr=%h v=%0b want addr=0007 v=0", mem_addr, instr_valid);
    end
    mem_ack = 1'b1; mem_rdata = 16'h7777; halt = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 15'd7 || instr !== 16'h7777) begin
      errors++; $display("FAIL halt_issue got v=%0b ipc=%h instr=%h want v=1 ipc=0007 instr=7777", instr_valid, instr_pc, instr);
    end
    @(negedge clk);
    halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (halted !== 1'b1 || mem_req !== 1'b0 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL halt_idle[%0d] got halted=%0b req=%0b v=%0b want halted=1 req=0 v=0", i, halted, mem_req, instr_valid);
      end
      mem_ack = (i % 3 == 0);
      halt = (i == 5);
      @(negedge clk);
    end
    mem_ack = 1'b0; halt = 1'b0;
    jump = 1'b1; jump_target = 15'h10;
    @(negedge clk);
    jump = 1'b0;
    checks++; if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 15'h10) begin
      errors++; $display("FAIL halt_resume got halted=%0b req=%0b addr=%h want halted=0 req=1 addr=0010", halted, mem_req, mem_addr);
    end
  endtask

  task automatic test_wrap();
    jump = 1'b1; jump_target = 15'h7FFF; mem_ack = 1'b1; mem_rdata = 16'h0;
    @(negedge clk);
    jump = 1'b0;
    checks++; if (mem_addr !== 15'h7FFF) begin errors++; $display("FAIL wrap_goto got addr=%h want 7fff", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 16'hABCD;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 15'h7FFF || instr !== 16'hABCD) begin
      errors++; $display("FAIL wrap_issue got v=%0b ipc=%h instr=%h want v=1 ipc=7fff instr=abcd", instr_valid, instr_pc, instr);
    end
    @(negedge clk);
    checks++; if (pc !== 15'h0 || mem_addr !== 15'h0 || mem_req !== 1'b1) begin
      errors++; $display("FAIL wrap_pc got pc=%h addr=%h req=%0b want pc=0000 addr=0000 req=1", pc, mem_addr, mem_req);
    end
  endtask

  task automatic test_async_reset();
    jump = 1'b1; jump_target = 15'h123; mem_ack = 1'b1;
    @(negedge clk);
    jump = 1'b0; mem_ack = 1'b0;
    checks++; if (mem_addr !== 15'h123 || mem_req !== 1'b1) begin
      errors++; $display("FAIL arst_setup got addr=%h req=%0b want addr=0123 req=1", mem_addr, mem_req);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (pc !== 15'h0 || mem_addr !== 15'h0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL arst_fetch got pc=%h addr=%h v=%0b halted=%0b want 0", pc, mem_addr, instr_valid, halted);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 15'h0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL arst_fetch_release got req=%0b addr=%h v=%0b want req=1 addr=0000 v=0", mem_req, mem_addr, instr_valid);
    end
    instr_ready = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'h9999;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr !== 16'h9999) begin
      errors++; $display("FAIL arst_issue_setup got v=%0b instr=%h want v=1 instr=9999", instr_valid, instr);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b0 || instr !== 16'h0 || instr_pc !== 15'h0 || pc !== 15'h0) begin
      errors++; $display("FAIL arst_issue got v=%0b instr=%h ipc=%h pc=%h want all 0", instr_valid, instr, instr_pc, pc);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (mem_addr !== 15'h0 || instr_valid !== 1'b0 || mem_req !== 1'b1) begin
      errors++; $display("FAIL arst_issue_release got addr=%h v=%0b req=%0b want addr=0000 v=0 req=1", mem_addr, instr_valid, mem_req);
    end
    instr_ready = 1'b1;
  endtask

  // Model: exp_next is the address of the instruction the stream owes next
  // (or is currently presenting); a redirect seen while fetching voids the
  // fetch in flight.
  task automatic test_random();
    logic [AW-1:0] exp_next = '0;
    logic exp_valid = 1'b0, exp_halt = 1'b0, redir = 1'b0, fetching;
    int issued = 0;
    logic [AW-1:0] tgt;
    rst = 1'b1; clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      fetching = !exp_valid && !exp_halt;
      checks++; if (instr_valid !== exp_valid || halted !== exp_halt || mem_req !== fetching) begin
        errors++; $display("FAIL rnd_ctrl@%0d got v=%0b h=%0b req=%0b want v=%0b h=%0b req=%0b",
                           cyc, instr_valid, halted, mem_req, exp_valid, exp_halt, fetching);
      end
      if (exp_valid) begin
        checks++; if (instr_pc !== exp_next || instr !== memf(exp_next)) begin
          errors++; $display("FAIL rnd_instr@%0d got ipc=%h instr=%h want ipc=%h instr=%h",
                             cyc, instr_pc, instr, exp_next, memf(exp_next));
        end
      end
      if (fetching && !redir) begin
        checks++; if (mem_addr !== exp_next) begin
          errors++; $display("FAIL rnd_addr@%0d got %h want %h", cyc, mem_addr, exp_next);
        end
      end
      // Stimulus for the coming edge; stray acks while idle must be ignored.
      mem_ack     = fetching ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      mem_rdata   = (fetching && mem_ack) ? memf(exp_next) : DW'($urandom);
      instr_ready = ($urandom_range(0, 3) != 0);
      jump        = ($urandom_range(0, 15) == 0);
      tgt         = AW'($urandom);
      jump_target = tgt;
      halt        = ($urandom_range(0, 19) == 0);
      if (fetching) begin
        if (mem_ack) begin
          if (jump) exp_next = tgt;
          if (!jump && !redir) begin exp_valid = 1'b1; issued++; end
          redir = 1'b0;
        end else if (jump) begin
          redir = 1'b1; exp_next = tgt;
        end
      end else if (exp_valid) begin
        if (jump) begin
          exp_valid = 1'b0; exp_next = tgt;
        end else if (instr_ready) begin
          exp_valid = 1'b0; exp_next = exp_next + 1'b1;
          if (halt) exp_halt = 1'b1;
        end
      end else if (jump) begin
        exp_halt = 1'b0; exp_next = tgt;
      end
      @(negedge clk);
    end
    clear_inputs();
    checks++; if (!(issued > 50)) begin
      errors++; $display("FAIL rnd_progress got %0d issued want more than 50", issued);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_jump_pending();
    test_halt_resume();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of the von Neumann CPU. It holds the program counter, issues one read per instruction over a req/ack memory handshake, and latches the returned word into an instruction register. It presents that word to the downstream decode/ALU datapath with a valid/ready handshake. It also supports jumps (redirects) and a halt/resume mechanism.

Parameters:
ADDR_W, 15, width of program counter and memory address
DATA_W, 16, instruction word width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
mem_req  out  1  read request to instruction memory
mem_addr  out  ADDR_W  read address, equal to pc
mem_ack  in  1  memory returns mem_rdata this cycle
mem_rdata  in  DATA_W  read data, valid when mem_ack=1
instr_valid  out  1  instr/instr_pc hold a fetched instruction
instr  out  DATA_W  instruction register
instr_pc  out  ADDR_W  address the instruction was fetched from
instr_ready  in  1  consumer accepts instr this cycle
jump  in  1  redirect fetch to jump_target
jump_target  in  ADDR_W  redirect address
halt  in  1  stop fetching after the accepted instruction
halted  out  1  unit is in HALTED state
pc  out  ADDR_W  current program counter

Behaviour:
- Reset (async, any state, including mid-request): state=FETCH, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, pend=0, pend_tgt=0, halted=0. mem_req is 1 from the first cycle after rst deasserts.
- States: FETCH, ISSUE, HALTED. All outputs are registered or decoded directly from the state; there is no input-to-output combinational path.
- mem_req = (state==FETCH); mem_addr = pc. Both are stable until mem_ack.
- FETCH, mem_ack=0: wait. If jump=1: pend<=1, pend_tgt<=jump_target. A later jump overwrites pend_tgt.
- FETCH, mem_ack=1 with jump=0 and pend=0: instr<=mem_rdata, instr_pc<=pc, pc<=pc+1 (mod 2^ADDR_W, so all-ones wraps to 0), instr_valid<=1, go to ISSUE.
- FETCH, mem_ack=1 with jump=1 or pend=1: discard mem_rdata, pc<=(jump ? jump_target : pend_tgt), pend<=0, stay in FETCH. A new request is issued the next cycle.
- ISSUE, instr_ready=1, jump=0, halt=0: instr_valid<=0, go to FETCH.
- ISSUE, instr_ready=1, halt=1, jump=0: instr_valid<=0, go to HALTED.
- ISSUE, jump=1 (with or without ready): instr_valid<=0, pc<=jump_target, go to FETCH. If ready=1 the instruction counts as consumed. Jump beats halt.
- ISSUE, instr_ready=0, jump=0: instr, instr_pc and instr_valid hold. halt is ignored.
- HALTED: halted=1, mem_req=0, instr_valid=0. jump=1 sets pc<=jump_target and goes to FETCH (resume). halt is ignored.
- halt is sampled only on accept in ISSUE.
- Latency: a mem_ack in cycle N gives instr_valid=1 in cycle N+1. Best-case throughput is one instruction per 2 cycles, with same-cycle ack and ready always 1.
- The memory must not assert mem_ack while mem_req=0. If it does, the ack is ignored.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding: FETCH=2'd0, ISSUE=2'd1, HALTED=2'd2
  - the ADDR_W and DATA_W defaults
  - RESET_PC
- Natural sub-module: pc_incrementer. It is a combinational ADDR_W ripple-carry +1 built from the existing elementary gates (xor_gate/and_gate half-adder chain). fetch_unit instantiates one.

Test Plan:
- Reset, then 3 fetches with memory acking 1 cycle after req. Data 0x1111/0x2222/0x3333 at addresses 0/1/2, ready=1 -> instr/instr_pc = (0x1111,0), (0x2222,1), (0x3333,2), with valid on the cycle after each ack; pc=3.
- Backpressure: hold ready=0 for 4 cycles in ISSUE -> instr and valid are stable, mem_req=0, pc unchanged; ready=1 -> next req at pc+1.
- Jump during an outstanding fetch at pc=5 with target=0x40, ack 3 cycles later -> data for address 5 is discarded, never valid; next mem_addr=0x40; first issued instr_pc=0x40.
- Halt on accept at instr_pc=7, then 10 idle cycles -> halted=1, mem_req=0 throughout; jump target=0x10 -> halted=0, mem_addr=0x10 next cycle.
- Wrap: pc=0x7FFF fetched and accepted -> pc=0x0000, next mem_addr=0x0000.
- Async rst pulse mid-FETCH (req high, no ack) and mid-ISSUE -> outputs cleared immediately; after release mem_addr=RESET_PC and instr_valid=0.
